wb_commit_serializer: RTL and testbench

- Takes the two per-cycle writeback channels of the dual-issue datapath (slot 0 older than slot 1) and serializes them, in program order, into one single-issue commit stream.
- Output matches the standard debug_wb_* interface used by the SoC trace-compare flow.
- Buffers bursts in a dual-push / single-pop FIFO and raises a backpressure request to the pipeline before the FIFO overflows.
- Sits beside the WB stage in the CPU top; its outputs drive debug_wb_pc / debug_wb_rf_*.

---
 rtl/cpu_debug_pkg.sv | 14 +
 rtl/wb_dual_push_fifo.sv | 69 ++++++
 rtl/wb_commit_serializer.sv | 92 +++++++++
 tb/tb_wb_commit_serializer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_debug_pkg.sv
// Shared debug-trace types: one writeback entry and the debug_wb_rf_wen encodings.
// Pure declarations; no logic, no timing.
package cpu_debug_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } wb_entry_t;

  localparam logic [3:0] DEBUG_WEN_ALL  = 4'hf;
  localparam logic [3:0] DEBUG_WEN_NONE = 4'h0;

endpackage

// File: rtl/wb_dual_push_fifo.sv
// Dual-push / single-pop ring buffer; pushed entries become head one edge later.
// A push pair that does not fit (after this cycle's pop) is dropped whole and accept reads 0.
module wb_dual_push_fifo #(
  parameter int  DEPTH  = 8,
  parameter type elem_t = logic [7:0]
) (
  input  logic                   sys_clk,
  input  logic                   resetn,
  input  logic                   push0,
  input  logic                   push1,
  input  elem_t                  data0,
  input  elem_t                  data1,
  input  logic                   pop,
  output elem_t                  head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   accept
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  elem_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr_p1;
  logic           pop_q;
  logic [1:0]     npush;
  logic [CW:0]    fill_next;
  logic           do_push;
  logic [CW-1:0]  count_next;

  always_comb begin
    pop_q      = pop && (count != '0);
    npush      = {1'b0, push0} + {1'b0, push1};
    // One extra bit so count + 2 cannot wrap before the compare.
    fill_next  = {1'b0, count} - {{CW{1'b0}}, pop_q} + {{(CW-1){1'b0}}, npush};
    accept     = fill_next <= (CW+1)'(DEPTH);
    do_push    = accept && (npush != 2'd0);
    wr_ptr_p1  = wr_ptr + {{(AW-1){1'b0}}, 1'b1};
    count_next = accept ? fill_next[CW-1:0] : (count - {{AW{1'b0}}, pop_q});
  end

  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop_q)
        rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      if (do_push)
        wr_ptr <= wr_ptr + AW'(npush);
      count <= count_next;
    end
  end

  // Slot 1 lands behind slot 0 when both push, otherwise at wr_ptr.
  always_ff @(posedge sys_clk) begin
    if (do_push) begin
      if (push0)
        mem[wr_ptr] <= data0;
      if (push1)
        mem[push0 ? wr_ptr_p1 : wr_ptr] <= data1;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_commit_serializer.sv
// Serializes dual-issue writeback into one debug_wb_* commit stream, one commit per cycle while buffered.
// Commit appears one edge after the entry reaches head; wb_stall warns early, overflowing pairs are dropped.
module wb_commit_serializer
  import cpu_debug_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int STALL_MARGIN = 4,
  parameter int FILTER_R0    = 1
) (
  input  logic        sys_clk,
  input  logic        resetn,
  input  logic        wb0_en,
  input  logic [4:0]  wb0_rd,
  input  logic [31:0] wb0_wdata,
  input  logic [31:0] wb0_pc,
  input  logic        wb1_en,
  input  logic [4:0]  wb1_rd,
  input  logic [31:0] wb1_wdata,
  input  logic [31:0] wb1_pc,
  output logic        wb_stall,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic        overflow,
  output logic [31:0] commit_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          v0;
  logic          v1;
  logic          pop;
  logic          accept;
  logic [CW-1:0] count;
  logic [CW-1:0] free_cnt;
  wb_entry_t     e0;
  wb_entry_t     e1;
  wb_entry_t     head;

  assign v0 = wb0_en && !((FILTER_R0 != 0) && (wb0_rd == 5'd0));
  assign v1 = wb1_en && !((FILTER_R0 != 0) && (wb1_rd == 5'd0));

  assign e0 = '{pc: wb0_pc, rd: wb0_rd, wdata: wb0_wdata};
  assign e1 = '{pc: wb1_pc, rd: wb1_rd, wdata: wb1_wdata};

  assign pop = (count != '0);

  wb_dual_push_fifo #(
    .DEPTH  (DEPTH),
    .elem_t (wb_entry_t)
  ) u_fifo (
    .sys_clk (sys_clk),
    .resetn  (resetn),
    .push0   (v0),
    .push1   (v1),
    .data0   (e0),
    .data1   (e1),
    .pop     (pop),
    .head    (head),
    .count   (count),
    .accept  (accept)
  );

  // Registered count only: the pipeline reacts a cycle late, the margin absorbs that.
  assign free_cnt = CW'(DEPTH) - count;
  assign wb_stall = free_cnt <= CW'(STALL_MARGIN);

  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= DEBUG_WEN_NONE;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
      overflow          <= 1'b0;
      commit_cnt        <= '0;
    end else begin
      if (pop) begin
        debug_wb_pc       <= head.pc;
        debug_wb_rf_wnum  <= head.rd;
        debug_wb_rf_wdata <= head.wdata;
        debug_wb_rf_wen   <= DEBUG_WEN_ALL;
        commit_cnt        <= commit_cnt + 32'd1;
      end else begin
        debug_wb_rf_wen   <= DEBUG_WEN_NONE;
      end
      if ((v0 || v1) && !accept)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_commit_serializer.sv
// Directed bench: vector table for single/dual/filtered commits, then fill-to-overflow and mid-burst reset sequences.
module tb_wb_commit_serializer;

  logic        sys_clk = 1'b0;
  logic        resetn;
  logic        wb0_en, wb1_en;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_wdata, wb0_pc, wb1_wdata, wb1_pc;
  logic        wb_stall;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        overflow;
  logic [31:0] commit_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 sys_clk = ~sys_clk;

  wb_commit_serializer dut (
    .sys_clk           (sys_clk),
    .resetn            (resetn),
    .wb0_en            (wb0_en),
    .wb0_rd            (wb0_rd),
    .wb0_wdata         (wb0_wdata),
    .wb0_pc            (wb0_pc),
    .wb1_en            (wb1_en),
    .wb1_rd            (wb1_rd),
    .wb1_wdata         (wb1_wdata),
    .wb1_pc            (wb1_pc),
    .wb_stall          (wb_stall),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .overflow          (overflow),
    .commit_cnt        (commit_cnt)
  );

  typedef struct {
    logic        en0;
    logic [4:0]  rd0;
    logic [31:0] wd0;
    logic [31:0] pc0;
    logic        en1;
    logic [4:0]  rd1;
    logic [31:0] wd1;
    logic [31:0] pc1;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] pc;
    logic [31:0] wdata;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl [15];
  logic [31:0] got_pc [$];
  logic [31:0] got_wd [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e0, input logic [4:0] r0, input logic [31:0] d0, input logic [31:0] p0,
                       input logic e1, input logic [4:0] r1, input logic [31:0] d1, input logic [31:0] p1);
    wb0_en = e0; wb0_rd = r0; wb0_wdata = d0; wb0_pc = p0;
    wb1_en = e1; wb1_rd = r1; wb1_wdata = d1; wb1_pc = p1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  // Advance one edge and sample 1 time unit later; log any commit.
  task automatic step();
    @(posedge sys_clk);
    #1;
    if (debug_wb_rf_wen == 4'hf) begin
      got_pc.push_back(debug_wb_pc);
      got_wd.push_back(debug_wb_rf_wdata);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wen"},   {28'h0, debug_wb_rf_wen}, 32'h0);
    chk({tag, "_pc"},    debug_wb_pc, 32'h0);
    chk({tag, "_wnum"},  {27'h0, debug_wb_rf_wnum}, 32'h0);
    chk({tag, "_wdata"}, debug_wb_rf_wdata, 32'h0);
    chk({tag, "_ovf"},   {31'h0, overflow}, 32'h0);
    chk({tag, "_cnt"},   commit_cnt, 32'h0);
    chk({tag, "_stall"}, {31'h0, wb_stall}, 32'h0);
  endtask

  initial begin
    tbl[0]  = '{1,5'd5,32'h1234,32'hbfc00000, 0,5'd0,32'h0,32'h0,        4'h0,5'd0,32'h0,32'h0,0};
    tbl[1]  = '{0,5'd0,32'h0,32'h0,           0,5'd0,32'h0,32'h0,        4'hf,5'd5,32'hbfc00000,32'h1234,1};
    tbl[2]  = '{0,5'd0,32'h0,32'h0,           0,5'd0,32'h0,32'h0,        4'h0,5'd5,32'hbfc00000,32'h1234,1};
    tbl[3]  = '{1,5'd1,32'h11,32'hbfc00010,   1,5'd2,32'h22,32'hbfc00014, 4'h0,5'd5,32'hbfc00000,32'h1234,1};
    tbl[4]  = '{0,5'd0,32'h0,32'h0,           0,5'd0,32'h0,32'h0,        4'hf,5'd1,32'hbfc00010,32'h11,2};
    tbl[5]  = '{0,5'd0,32'h0,32'h0,           0,5'd0,32'h0,32'h0,        4'hf,5'd2,32'hbfc00014,32'h22,3};
    tbl[6]  = '{0,5'd0,32'h0,32'h0,           0,5'd0,32'h0,32'h0,        4'h0,5'd2,32'hbfc00014,32'h22,3};
    tbl[7]  = '{1,5'd0,32'h33,32'hbfc00018,   1,5'd3,32'h44,32'hbfc0001c, 4'h0,5'd2,32'hbfc00014,32'h22,3};
    tbl[8]  = '{0,5'd0,32'h0,32'h0,           0,5'd0,32'h0,32'h0,        4'hf,5'd3,32'hbfc0001c,32'h44,4};
    tbl[9]  = '{0,5'd0,32'h0,32'h0,           0,5'd0,32'h0,32'h0,        4'h0,5'd3,32'hbfc0001c,32'h44,4};
    tbl[10] = '{0,5'd0,32'h0,32'h0,           1,5'd7,32'h77,32'hbfc00024, 4'h0,5'd3,32'hbfc0001c,32'h44,4};
    tbl[11] = '{0,5'd0,32'h0,32'h0,           0,5'd0,32'h0,32'h0,        4'hf,5'd7,32'hbfc00024,32'h77,5};
    tbl[12] = '{0,5'd0,32'h0,32'h0,           0,5'd0,32'h0,32'h0,        4'h0,5'd7,32'hbfc00024,32'h77,5};
    tbl[13] = '{0,5'd9,32'h99,32'hbfc00028,   0,5'd0,32'h0,32'h0,        4'h0,5'd7,32'hbfc00024,32'h77,5};
    tbl[14] = '{0,5'd0,32'h0,32'h0,           0,5'd0,32'h0,32'h0,        4'h0,5'd7,32'hbfc00024,32'h77,5};

    resetn = 1'b0;
    idle();
    step();
    step();
    chk_reset_state("reset");
    resetn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].en0, tbl[i].rd0, tbl[i].wd0, tbl[i].pc0,
            tbl[i].en1, tbl[i].rd1, tbl[i].wd1, tbl[i].pc1);
      step();
      chk($sformatf("v%0d_wen", i),   {28'h0, debug_wb_rf_wen}, {28'h0, tbl[i].wen});
      chk($sformatf("v%0d_wnum", i),  {27'h0, debug_wb_rf_wnum}, {27'h0, tbl[i].wnum});
      chk($sformatf("v%0d_pc", i),    debug_wb_pc, tbl[i].pc);
      chk($sformatf("v%0d_wdata", i), debug_wb_rf_wdata, tbl[i].wdata);
      chk($sformatf("v%0d_cnt", i),   commit_cnt, tbl[i].cnt);
      chk($sformatf("v%0d_stall", i), {31'h0, wb_stall}, 32'h0);
      chk($sformatf("v%0d_ovf", i),   {31'h0, overflow}, 32'h0);
    end

    // Fill: count after each edge 2,3,4,5,6,7,8 then pair 7 is rejected (8-1+2 > 8).
    got_pc.delete();
    got_wd.delete();
    for (int p = 0; p < 8; p++) begin
      drive(1'b1, 5'(2*p+1), ~(32'h80000000 + 32'(p*8)), 32'h80000000 + 32'(p*8),
            1'b1, 5'(2*p+2), ~(32'h80000004 + 32'(p*8)), 32'h80000004 + 32'(p*8));
      step();
      chk($sformatf("fill%0d_stall", p), {31'h0, wb_stall}, (p >= 2) ? 32'h1 : 32'h0);
      chk($sformatf("fill%0d_ovf", p),   {31'h0, overflow}, (p == 7) ? 32'h1 : 32'h0);
    end
    idle();
    for (int i = 0; i < 12; i++) step();
    chk("fill_ncommits", 32'(got_pc.size()), 32'd14);
    for (int k = 0; k < 14 && k < got_pc.size(); k++) begin
      chk($sformatf("fill_pc%0d", k), got_pc[k], 32'h80000000 + 32'(k*4));
      chk($sformatf("fill_wd%0d", k), got_wd[k], ~(32'h80000000 + 32'(k*4)));
    end
    chk("fill_cnt", commit_cnt, 32'd19);
    chk("fill_ovf_sticky", {31'h0, overflow}, 32'h1);
    chk("fill_drained_stall", {31'h0, wb_stall}, 32'h0);
    chk("fill_drained_wen", {28'h0, debug_wb_rf_wen}, 32'h0);

    // Four dual writes leave five entries buffered, then reset.
    for (int p = 0; p < 4; p++) begin
      drive(1'b1, 5'd10, 32'hd0 + 32'(p), 32'h90000000 + 32'(p*8),
            1'b1, 5'd11, 32'hd8 + 32'(p), 32'h90000004 + 32'(p*8));
      step();
    end
    chk("pre_rst_stall", {31'h0, wb_stall}, 32'h1);
    idle();
    resetn = 1'b0;
    step();
    chk_reset_state("midrst");
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("post_rst%0d_wen", i), {28'h0, debug_wb_rf_wen}, 32'h0);
      chk($sformatf("post_rst%0d_cnt", i), commit_cnt, 32'h0);
    end

    drive(1'b1, 5'd12, 32'hcafe, 32'hbfc00100, 1'b0, 5'd0, 32'h0, 32'h0);
    step();
    idle();
    chk("after_rst_lat1_wen", {28'h0, debug_wb_rf_wen}, 32'h0);
    step();
    chk("after_rst_wen", {28'h0, debug_wb_rf_wen}, 32'hf);
    chk("after_rst_pc", debug_wb_pc, 32'hbfc00100);
    chk("after_rst_wnum", {27'h0, debug_wb_rf_wnum}, 32'd12);
    chk("after_rst_cnt", commit_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
